// File: rtl/mem_vout_buffer_ctrl.sv
// Read-side DDR frame buffer controller: issues fixed-length read bursts behind the
// writer's committed-burst count and streams returned beats out through a FWFT FIFO.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a frame start rising edge
// WAIT    | deciding: issue a burst, finish the frame, or hold
// REQ     | read request launched (address/length registered on entry)
// READING | beats returning, waiting for the burst finish pulse
// END     | burst accounted, back to WAIT
// DONE    | frame_done_o pulse, back to IDLE
module mem_vout_buffer_ctrl #(
    parameter int MEM_SEL_BIT   = 1,
    parameter int ADDR_WIDTH    = 30,
    parameter int MEM_DATA_BITS = 256,
    parameter int BURST_LEN     = 128,
    parameter int FIFO_DEPTH    = 512
) (
    input  logic                     ddr_clk_i,
    input  logic                     ddr_rst_n_i,
    input  logic                     laser_start_i,
    input  logic [17:0]              wr_burst_line_i,
    output logic [17:0]              rd_burst_line_o,
    output logic                     rd_ddr_req_o,
    output logic [7:0]               rd_ddr_len_o,
    output logic [ADDR_WIDTH-1:0]    rd_ddr_addr_o,
    input  logic [MEM_DATA_BITS-1:0] rd_ddr_data_i,
    input  logic                     rd_ddr_data_vld_i,
    input  logic                     rd_ddr_finish_i,
    output logic [MEM_DATA_BITS-1:0] data_o,
    output logic                     data_vld_o,
    input  logic                     data_rdy_i,
    output logic                     frame_done_o,
    output logic                     fifo_overflow_o
);
    localparam int   PTR_W = $clog2(FIFO_DEPTH);
    localparam int   LVL_W = PTR_W + 1;
    localparam logic SEL   = 1'(MEM_SEL_BIT);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_REQ, ST_READING, ST_END, ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     start_q, start_d, start_dly_q, start_dly_d;
    logic                     rise_q, rise_d, fall_q, fall_d;
    logic [17:0]              line_q, line_d;
    logic [LVL_W-1:0]         level_q, level_d;
    logic                     end_seen_q, end_seen_d;
    logic                     req_q, req_d;
    logic [7:0]               len_q, len_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic                     done_q, done_d;
    logic                     ovf_q, ovf_d;
    logic [MEM_DATA_BITS-1:0] beat_q, beat_d;
    logic                     beat_vld_q, beat_vld_d;
    logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]         count_q, count_d;
    logic [MEM_DATA_BITS-1:0] mem [FIFO_DEPTH];

    logic avail, space_ok, pop, wr_en, req_entry;

    always_comb begin
        state_d     = state_q;
        start_d     = laser_start_i;
        start_dly_d = start_q;
        rise_d      = start_q & ~start_dly_q;
        fall_d      = ~start_q & start_dly_q;
        line_d      = line_q;
        level_d     = level_q;
        end_seen_d  = end_seen_q;
        req_d       = req_q;
        len_d       = len_q;
        addr_d      = addr_q;
        done_d      = 1'b0;
        ovf_d       = ovf_q;
        beat_d      = rd_ddr_data_i;
        beat_vld_d  = rd_ddr_data_vld_i;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        req_entry   = 1'b0;

        avail    = (wr_burst_line_i - line_q) != 18'd0;
        space_ok = level_q <= LVL_W'(FIFO_DEPTH - BURST_LEN);
        pop      = (count_q != '0) && data_rdy_i;
        wr_en    = beat_vld_q && (count_q != LVL_W'(FIFO_DEPTH));

        case (state_q)
            ST_IDLE: begin
                if (rise_q) begin
                    line_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (avail && space_ok) begin
                    req_entry = 1'b1;
                    state_d   = ST_REQ;
                end else if (end_seen_q && !avail) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_REQ: state_d = ST_READING;
            ST_READING: begin
                if (rd_ddr_finish_i) begin
                    line_d  = line_q + 18'd1;
                    state_d = ST_END;
                end
            end
            ST_END:  state_d = ST_WAIT;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (req_entry) begin
            req_d  = 1'b1;
            len_d  = 8'(BURST_LEN);
            addr_d = ADDR_WIDTH'({2'b00, SEL, line_q, 9'b0});
        end else if (req_q && (rd_ddr_data_vld_i || rd_ddr_finish_i)) begin
            req_d = 1'b0;
        end

        // Saturate at zero: leftover beats from a previous frame may still be popped
        // after the reservation count was cleared at frame start.
        if (pop && level_q != '0) level_d = level_q - LVL_W'(1);
        if (req_entry) level_d = level_d + LVL_W'(BURST_LEN);
        if (state_q == ST_IDLE && rise_q) level_d = '0;

        if (state_q == ST_IDLE) end_seen_d = 1'b0;
        else if (fall_q)        end_seen_d = 1'b1;

        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + LVL_W'(wr_en) - LVL_W'(pop);
        if (beat_vld_q && !wr_en) ovf_d = 1'b1;
    end

    always_ff @(posedge ddr_clk_i or negedge ddr_rst_n_i) begin
        if (!ddr_rst_n_i) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            start_dly_q <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            line_q      <= '0;
            level_q     <= '0;
            end_seen_q  <= 1'b0;
            req_q       <= 1'b0;
            len_q       <= '0;
            addr_q      <= '0;
            done_q      <= 1'b0;
            ovf_q       <= 1'b0;
            beat_q      <= '0;
            beat_vld_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            start_dly_q <= start_dly_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            line_q      <= line_d;
            level_q     <= level_d;
            end_seen_q  <= end_seen_d;
            req_q       <= req_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            ovf_q       <= ovf_d;
            beat_q      <= beat_d;
            beat_vld_q  <= beat_vld_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Beats pass through beat_q first, which gives the one-cycle FWFT latency.
    always_ff @(posedge ddr_clk_i) begin
        if (wr_en) mem[wr_ptr_q] <= beat_q;
    end

    assign rd_burst_line_o = line_q;
    assign rd_ddr_req_o    = req_q;
    assign rd_ddr_len_o    = len_q;
    assign rd_ddr_addr_o   = addr_q;
    assign data_vld_o      = count_q != '0;
    assign data_o          = data_vld_o ? mem[rd_ptr_q] : '0;
    assign frame_done_o    = done_q;
    assign fifo_overflow_o = ovf_q;
endmodule

// File: tb/tb_mem_vout_buffer_ctrl.sv
// Directed bench for mem_vout_buffer_ctrl with a behavioural DDR read responder
// and an in-order output checker.
module tb_mem_vout_buffer_ctrl;
    logic         clk;
    logic         rst_n;
    logic         laser_start_i;
    logic [17:0]  wr_burst_line_i;
    logic [17:0]  rd_burst_line_o;
    logic         rd_ddr_req_o;
    logic [7:0]   rd_ddr_len_o;
    logic [29:0]  rd_ddr_addr_o;
    logic [255:0] rd_ddr_data_i;
    logic         rd_ddr_data_vld_i;
    logic         rd_ddr_finish_i;
    logic [255:0] data_o;
    logic         data_vld_o;
    logic         data_rdy_i;
    logic         frame_done_o;
    logic         fifo_overflow_o;

    mem_vout_buffer_ctrl #(
        .MEM_SEL_BIT(1), .ADDR_WIDTH(30), .MEM_DATA_BITS(256),
        .BURST_LEN(128), .FIFO_DEPTH(512)
    ) dut (
        .ddr_clk_i(clk), .ddr_rst_n_i(rst_n),
        .laser_start_i(laser_start_i), .wr_burst_line_i(wr_burst_line_i),
        .rd_burst_line_o(rd_burst_line_o), .rd_ddr_req_o(rd_ddr_req_o),
        .rd_ddr_len_o(rd_ddr_len_o), .rd_ddr_addr_o(rd_ddr_addr_o),
        .rd_ddr_data_i(rd_ddr_data_i), .rd_ddr_data_vld_i(rd_ddr_data_vld_i),
        .rd_ddr_finish_i(rd_ddr_finish_i), .data_o(data_o), .data_vld_o(data_vld_o),
        .data_rdy_i(data_rdy_i), .frame_done_o(frame_done_o),
        .fifo_overflow_o(fifo_overflow_o)
    );

    int          vec_cnt = 0;
    int          err_cnt = 0;
    int unsigned req_cnt = 0, req_base = 0;
    int unsigned beat_ctr = 0, beat_base = 0;
    int unsigned pop_cnt = 0, pop_base = 0;
    int unsigned done_cnt = 0, done_base = 0;
    logic [17:0] done_line = '0;
    logic [29:0] req_addr [32];
    logic [7:0]  req_len  [32];
    int          extra_idx = -1;
    bit          model_en = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check_val({tag, "_req"},  rd_ddr_req_o, 0);
        check_val({tag, "_len"},  rd_ddr_len_o, 0);
        check_val({tag, "_addr"}, rd_ddr_addr_o, 0);
        check_val({tag, "_vld"},  data_vld_o, 0);
        check_val({tag, "_data"}, data_o, 0);
        check_val({tag, "_line"}, rd_burst_line_o, 0);
        check_val({tag, "_done"}, frame_done_o, 0);
        check_val({tag, "_ovf"},  fifo_overflow_o, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        laser_start_i = 1'b0;
        wr_burst_line_i = '0;
        data_rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        req_base  = req_cnt;
        beat_base = beat_ctr;
        pop_base  = pop_cnt;
        done_base = done_cnt;
    endtask

    task automatic rise_start();
        @(posedge clk);
        #1 laser_start_i = 1'b1;
    endtask

    task automatic drop_start();
        @(posedge clk);
        #1 laser_start_i = 1'b0;
    endtask

    // DDR read responder: 128 incrementing beats per request (129 on extra_idx), then finish.
    initial begin
        rd_ddr_data_vld_i = 1'b0;
        rd_ddr_finish_i   = 1'b0;
        rd_ddr_data_i     = '0;
        forever begin
            @(negedge clk);
            if (model_en && rst_n && rd_ddr_req_o) begin
                int n;
                req_addr[req_cnt % 32] = rd_ddr_addr_o;
                req_len[req_cnt % 32]  = rd_ddr_len_o;
                n = (int'(req_cnt) == extra_idx) ? 129 : 128;
                req_cnt++;
                @(posedge clk);
                #1;
                for (int i = 0; i < n; i++) begin
                    rd_ddr_data_vld_i = 1'b1;
                    rd_ddr_data_i     = {8{beat_ctr}};
                    beat_ctr++;
                    @(posedge clk);
                    #1;
                end
                rd_ddr_data_vld_i = 1'b0;
                rd_ddr_finish_i   = 1'b1;
                @(posedge clk);
                #1 rd_ddr_finish_i = 1'b0;
            end
        end
    end

    // Output consumer: every pop must carry the next beat issued since the last reset.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && data_vld_o && data_rdy_i) begin
                check_val("beat", data_o, {8{beat_base + (pop_cnt - pop_base)}});
                pop_cnt++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done_o) begin
                done_cnt++;
                done_line = rd_burst_line_o;
            end
        end
    end

    initial begin
        int k;
        rst_n = 1'b0;
        laser_start_i = 1'b0;
        wr_burst_line_i = '0;
        data_rdy_i = 1'b0;

        // Reset values, then a reset asserted mid-request.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outs("rst_hold");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outs("rst_rel");
        wr_burst_line_i = 18'd1;
        rise_start();
        k = 0;
        while (!rd_ddr_req_o && k < 20) begin @(negedge clk); k++; end
        check_val("rst_req_seen", rd_ddr_req_o, 1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_val("rst_async_req", rd_ddr_req_o, 0);
        laser_start_i = 1'b0;
        wr_burst_line_i = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle_outs("rst_rel2");
        model_en = 1'b1;

        // Nominal frame: three bursts, consumer always ready.
        do_reset();
        data_rdy_i = 1'b1;
        rise_start();
        repeat (6) @(posedge clk);
        #1 wr_burst_line_i = 18'd3;
        k = 0;
        while (rd_burst_line_o != 18'd3 && k < 3000) begin @(negedge clk); k++; end
        check_val("nom_line", rd_burst_line_o, 3);
        k = 0;
        while (pop_cnt - pop_base < 384 && k < 300) begin @(negedge clk); k++; end
        check_val("nom_pops", pop_cnt - pop_base, 384);
        check_val("nom_reqs", req_cnt - req_base, 3);
        check_val("nom_addr0", req_addr[(req_base + 0) % 32], 30'h0800_0000);
        check_val("nom_addr1", req_addr[(req_base + 1) % 32], 30'h0800_0200);
        check_val("nom_addr2", req_addr[(req_base + 2) % 32], 30'h0800_0400);
        check_val("nom_len0", req_len[(req_base + 0) % 32], 128);
        check_val("nom_len2", req_len[(req_base + 2) % 32], 128);
        check_val("nom_no_done_yet", done_cnt - done_base, 0);
        drop_start();
        repeat (20) @(negedge clk);
        check_val("nom_done", done_cnt - done_base, 1);
        check_val("nom_vld_empty", data_vld_o, 0);

        // Backpressure: four bursts fill the FIFO, the fifth waits for 128 pops.
        do_reset();
        wr_burst_line_i = 18'd10;
        rise_start();
        k = 0;
        while (rd_burst_line_o != 18'd4 && k < 2000) begin @(negedge clk); k++; end
        repeat (50) @(negedge clk);
        check_val("bp_stall_reqs", req_cnt - req_base, 4);
        check_val("bp_stall_line", rd_burst_line_o, 4);
        check_val("bp_vld", data_vld_o, 1);
        @(posedge clk);
        #1 data_rdy_i = 1'b1;
        repeat (127) @(posedge clk);
        @(negedge clk);
        check_val("bp_127_pops", req_cnt - req_base, 4);
        @(posedge clk);
        #1 data_rdy_i = 1'b0;
        k = 0;
        while (req_cnt - req_base < 5 && k < 50) begin @(negedge clk); k++; end
        check_val("bp_fifth_req", req_cnt - req_base, 5);
        check_val("bp_addr4", req_addr[(req_base + 4) % 32], 30'h0800_0800);
        k = 0;
        while (rd_burst_line_o != 18'd5 && k < 300) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check_val("bp_pops", pop_cnt - pop_base, 128);
        check_val("bp_ovf", fifo_overflow_o, 0);
        repeat (30) @(negedge clk);
        check_val("bp_no_sixth", req_cnt - req_base, 5);

        // Empty frame.
        do_reset();
        data_rdy_i = 1'b1;
        rise_start();
        repeat (10) @(posedge clk);
        drop_start();
        repeat (20) @(negedge clk);
        check_val("empty_reqs", req_cnt - req_base, 0);
        check_val("empty_done", done_cnt - done_base, 1);
        check_val("empty_line", rd_burst_line_o, 0);

        // Start latency, then the frame ends while the first burst is in flight.
        do_reset();
        data_rdy_i = 1'b1;
        wr_burst_line_i = 18'd2;
        rise_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("lat_pre_req", rd_ddr_req_o, 0);
        @(posedge clk);
        @(negedge clk);
        check_val("lat_req", rd_ddr_req_o, 1);
        check_val("lat_addr", rd_ddr_addr_o, 30'h0800_0000);
        check_val("lat_len", rd_ddr_len_o, 128);
        k = 0;
        while (beat_ctr == beat_base && k < 20) begin @(negedge clk); k++; end
        drop_start();
        k = 0;
        while (done_cnt == done_base && k < 1000) begin @(negedge clk); k++; end
        repeat (10) @(negedge clk);
        check_val("fall_done", done_cnt - done_base, 1);
        check_val("fall_done_line", done_line, 2);
        check_val("fall_reqs", req_cnt - req_base, 2);
        check_val("fall_addr1", req_addr[(req_base + 1) % 32], 30'h0800_0200);
        check_val("fall_pops", pop_cnt - pop_base, 256);

        // Overflow: the fourth burst returns one beat too many into a full FIFO.
        do_reset();
        wr_burst_line_i = 18'd4;
        extra_idx = int'(req_base) + 3;
        rise_start();
        k = 0;
        while (rd_burst_line_o != 18'd3 && k < 2000) begin @(negedge clk); k++; end
        check_val("ovf_before", fifo_overflow_o, 0);
        k = 0;
        while (rd_burst_line_o != 18'd4 && k < 500) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check_val("ovf_set", fifo_overflow_o, 1);
        repeat (30) @(negedge clk);
        check_val("ovf_sticky", fifo_overflow_o, 1);
        check_val("ovf_reqs", req_cnt - req_base, 4);
        @(posedge clk);
        #1 data_rdy_i = 1'b1;
        k = 0;
        while (pop_cnt - pop_base < 512 && k < 1000) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        check_val("ovf_pops", pop_cnt - pop_base, 512);
        check_val("ovf_dropped", data_vld_o, 0);
        check_val("ovf_still", fifo_overflow_o, 1);
        extra_idx = -1;
        do_reset();
        @(negedge clk);
        check_val("ovf_cleared", fifo_overflow_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
